uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16, clk cycles per serial bit; legal range 4..1023.
REQ-002 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..8.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 rxIn  input  1  raw serial line, idle high, asynchronous to clk.
REQ-006 rdAck  input  1  consumer acknowledge; one-cycle pulse clears the flag pair.
REQ-007 dataOut  output  DATA_BITS  last received data word, LSB = first bit received.
REQ-008 flagSet  output  1  one-cycle strobe to the flag pair; loads flagDin.
REQ-009 flagDin  output  1  frame status for the flag pair: 1 = good stop bit, 0 = framing error.
REQ-010 flagClr  output  1  one-cycle clear strobe to the flag pair.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 rxIn passes through a 2-flop synchronizer (reset value 1); all logic uses the synchronized value rxS.
REQ-013 States: IDLE, START, DATA, STOP; state register with 0..CLKS_PER_BIT-1 bit-timer and 0..DATA_BITS-1 bit-index counter.
REQ-014 IDLE: on rxS=0, go to START and clear bit-timer; otherwise stay.
REQ-015 START: at bit-timer = CLKS_PER_BIT/2-1 (mid start bit), if rxS=0 go to DATA with timer cleared, else false start: return to IDLE, no strobes.
REQ-016 DATA: at bit-timer = CLKS_PER_BIT-1, shift rxS into shift register MSB side (right shift, LSB first), clear timer, increment bit-index; after bit-index DATA_BITS-1 go to STOP.
REQ-017 STOP: at bit-timer = CLKS_PER_BIT-1, copy shift register to dataOut, assert flagSet for exactly one cycle with flagDin = rxS, return to IDLE.
REQ-018 dataOut updates on framing error as well as good frames; it holds between frames.
REQ-019 flagDin holds its last value when flagSet is low.
REQ-020 flagClr = one-cycle pulse in the cycle after rdAck is sampled high; independent of state.
REQ-021 rdAck and flagSet in the same cycle: flagSet issued, that rdAck discarded (no flagClr); new frame status is never lost.
REQ-022 Latency: flagSet asserts 2 + (CLKS_PER_BIT/2) + (DATA_BITS+1)*CLKS_PER_BIT cycles after the rxIn falling edge (±1 sync cycle).
REQ-023 rxIn low at STOP sample (break/framing error): flagDin=0, return to IDLE; IDLE restarts only on a further rxS=0, so a held-low line re-triggers START immediately.
REQ-024 rxIn glitches shorter than CLKS_PER_BIT/2 cycles in IDLE produce no strobe.

Reset
REQ-025 reset asserted: state=IDLE, timers=0, shift register=0, dataOut=0, flagSet=0, flagDin=0, flagClr=0, busy=0, synchronizer flops=1, immediately and independent of clk.
REQ-026 reset mid-frame aborts the frame with no strobe; reception resumes with the next falling edge after reset release.

Structure
REQ-027 Shared package uart_pkg holds the state enumeration encoding and default CLKS_PER_BIT/DATA_BITS constants.
REQ-028 One sub-module natural: uart_bit_timer (bit-timer counter with clear, mid-bit and end-bit compare outputs).
REQ-029 flag pair storage stays outside this block; flagSet/flagDin/flagClr wire directly to its set/dIn/reset ports.

Verification (CLKS_PER_BIT=16, DATA_BITS=8)
REQ-030 Frame 0xA5, stop=1 -> dataOut=0xA5, one flagSet with flagDin=1, ~154 cycles after falling edge, busy low next cycle.
REQ-031 Frame 0x3C, stop=0 -> dataOut=0x3C, flagSet with flagDin=0, FSM back in IDLE.
REQ-032 rxIn low pulse of 5 cycles in IDLE -> START entered, false start, no flagSet, dataOut unchanged.
REQ-033 rdAck pulsed coincident with flagSet -> no flagClr; rdAck 3 cycles later -> flagClr one cycle after.
REQ-034 reset asserted during DATA bit 4 of 0xFF frame -> all outputs zero asynchronously; next frame 0x55 received correctly.
REQ-035 Back-to-back frames 0x01, 0x80 with no idle gap -> two flagSet strobes, dataOut 0x01 then 0x80, flagDin=1 both.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and the
// default frame timing used when a parent does not override the parameters.
package uart_pkg;

  localparam int DEFAULT_CLKS_PER_BIT = 16;
  localparam int DEFAULT_DATA_BITS    = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } rxState_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer for the UART receiver. Counts clk cycles inside one serial
// bit and flags the middle of the bit (start-bit validation point) and the
// last cycle of the bit (data/stop sampling point). The count wraps by itself
// at the end of a bit so an un-cleared run stays periodic.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  output logic o_midBit,
  output logic o_endBit
);

  localparam int            TW        = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] MID_COUNT = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] END_COUNT = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] r_count;

  // Advance the in-bit cycle count, restarting on clear or at the end of a bit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear || (r_count == END_COUNT)) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + TW'(1);
    end
  end

  assign o_midBit = (r_count == MID_COUNT);
  assign o_endBit = (r_count == END_COUNT);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller. Synchronizes the raw serial line, frames it with a
// start/data/stop FSM, and drives an external status flag pair: flagSet loads
// the frame status (good stop bit or framing error) and flagClr clears it when
// the consumer acknowledges. The received word is presented on dataOut.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxIn,
  input  logic                 rdAck,
  output logic [DATA_BITS-1:0] dataOut,
  output logic                 flagSet,
  output logic                 flagDin,
  output logic                 flagClr,
  output logic                 busy
);

  localparam int            IW       = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rxS;
  rxState_t             r_state;
  rxState_t             w_nextState;
  logic [IW-1:0]        r_bitIdx;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_dataOut;
  logic                 r_flagSet;
  logic                 r_flagDin;
  logic                 r_flagClr;
  logic                 w_midBit;
  logic                 w_endBit;
  logic                 w_timerClr;
  logic                 w_shiftEn;
  logic                 w_frameDone;
  logic                 w_busy;

  // Two-flop synchronizer; resets to the idle-high line level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rxIn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxS = r_sync2;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bitTimer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_timerClr),
    .o_midBit (w_midBit),
    .o_endBit (w_endBit)
  );

  // Frame FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state: a start bit must still be low at mid-bit, otherwise it was a glitch
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!w_rxS) w_nextState = ST_START;
      end
      ST_START: begin
        if (w_midBit) w_nextState = w_rxS ? ST_IDLE : ST_DATA;
      end
      ST_DATA: begin
        if (w_endBit && (r_bitIdx == LAST_IDX)) w_nextState = ST_STOP;
      end
      ST_STOP: begin
        if (w_endBit) w_nextState = ST_IDLE;
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // FSM outputs: timer restarts at each sampling point, which moves sampling to mid-bit
  always_comb begin
    w_timerClr  = 1'b0;
    w_shiftEn   = 1'b0;
    w_frameDone = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_timerClr = 1'b1;
        w_busy     = 1'b0;
      end
      ST_START: begin
        w_timerClr = w_midBit;
      end
      ST_DATA: begin
        w_timerClr = w_endBit;
        w_shiftEn  = w_endBit;
      end
      ST_STOP: begin
        w_timerClr  = w_endBit;
        w_frameDone = w_endBit;
      end
      default: begin
        w_timerClr = 1'b1;
      end
    endcase
  end

  // Shift data bits in LSB first and track which bit of the word is next
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift  <= '0;
      r_bitIdx <= '0;
    end else if (w_shiftEn) begin
      r_shift  <= {w_rxS, r_shift[DATA_BITS-1:1]};
      r_bitIdx <= (r_bitIdx == LAST_IDX) ? '0 : r_bitIdx + IW'(1);
    end
  end

  // Publish the word and its stop-bit status together; both hold until the next frame
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dataOut <= '0;
      r_flagSet <= 1'b0;
      r_flagDin <= 1'b0;
    end else begin
      r_flagSet <= w_frameDone;
      if (w_frameDone) begin
        r_dataOut <= r_shift;
        r_flagDin <= w_rxS;
      end
    end
  end

  // Acknowledge clears the flag pair, except an ack seen while a new status is being set
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_flagClr <= 1'b0;
    end else begin
      r_flagClr <= rdAck & ~r_flagSet;
    end
  end

  assign dataOut = r_dataOut;
  assign flagSet = r_flagSet;
  assign flagDin = r_flagDin;
  assign flagClr = r_flagClr;
  assign busy    = w_busy;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl. Frames are serialized from plain
// data/stop values; a scoreboard of sent frames predicts each flagSet strobe
// (word, status, latency from the falling edge) and strobe counts.
module tb_uart_rx_ctrl;

  localparam int CPB         = 16;
  localparam int DB          = 8;
  localparam int NOM_LATENCY = 2 + CPB / 2 + (DB + 1) * CPB;

  typedef struct {
    logic [DB-1:0] data;
    logic          stopBit;
    int            startCyc;
  } frame_t;

  logic          clk;
  logic          reset;
  logic          rxIn;
  logic          rdAck;
  logic [DB-1:0] dataOut;
  logic          flagSet;
  logic          flagDin;
  logic          flagClr;
  logic          busy;

  frame_t        expQ[$];
  frame_t        monFrame;
  int            checks      = 0;
  int            errors      = 0;
  int            cyc         = 0;
  int            strobes     = 0;
  int            framesSent  = 0;
  int            lat;
  logic [DB-1:0] lastExpData = '0;
  logic          sawBusy;

  uart_rx_ctrl #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rxIn    (rxIn),
    .rdAck   (rdAck),
    .dataOut (dataOut),
    .flagSet (flagSet),
    .flagDin (flagDin),
    .flagClr (flagClr),
    .busy    (busy)
  );

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used to time strobes against the frame's falling edge
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Safety net so the run can never hang
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic driveBit(input logic b);
    rxIn = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  // Serialize one frame and register what the receiver should report for it
  task automatic applyStimulus(input logic [DB-1:0] data, input logic stopBit,
                               input int idleCycles);
    frame_t f;
    f.data     = data;
    f.stopBit  = stopBit;
    f.startCyc = cyc;
    expQ.push_back(f);
    framesSent++;
    lastExpData = data;
    driveBit(1'b0);
    for (int i = 0; i < DB; i++) driveBit(data[i]);
    driveBit(stopBit);
    rxIn = 1'b1;
    for (int i = 0; i < idleCycles; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: every strobe must match the oldest outstanding frame
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && flagSet) begin
        strobes++;
        if (expQ.size() == 0) begin
          checkOutput("unexpectedStrobe", 32'd1, 32'd0);
        end else begin
          monFrame = expQ.pop_front();
          lat = cyc - monFrame.startCyc;
          checkOutput("dataOut", 32'(dataOut), 32'(monFrame.data));
          checkOutput("flagDin", 32'(flagDin), 32'(monFrame.stopBit));
          checkOutput("latency",
                      (lat >= NOM_LATENCY - 1 && lat <= NOM_LATENCY + 1) ? NOM_LATENCY : lat,
                      NOM_LATENCY);
          checkOutput("busyAtStrobe", 32'(busy), 32'd0);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    rxIn  = 1'b1;
    rdAck = 1'b0;
    #1 reset = 1'b1;
    #1;
    checkOutput("rstDataOut", 32'(dataOut), 32'd0);
    checkOutput("rstFlagSet", 32'(flagSet), 32'd0);
    checkOutput("rstFlagDin", 32'(flagDin), 32'd0);
    checkOutput("rstFlagClr", 32'(flagClr), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end

    // Good frame and framing-error frame
    applyStimulus(8'hA5, 1'b1, 20);
    applyStimulus(8'h3C, 1'b0, 20);
    checkOutput("idleAfterBreak", 32'(busy), 32'd0);

    // Short low glitch: START is entered but abandoned at mid-bit
    rxIn = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rxIn = 1'b1;
    sawBusy = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (busy) sawBusy = 1'b1;
    end
    checkOutput("glitchStart", 32'(sawBusy), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("glitchNoStrobe", strobes, framesSent);
    checkOutput("glitchDataHold", 32'(dataOut), 32'(lastExpData));
    checkOutput("glitchIdle", 32'(busy), 32'd0);

    // Ack coincident with the strobe is dropped; a later ack clears
    fork
      applyStimulus(8'h96, 1'b1, 20);
      begin
        bit got;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
          @(negedge clk);
          if (flagSet) got = 1'b1;
        end
        if (!got) begin
          checkOutput("ackWaitTimeout", 32'd0, 32'd1);
        end else begin
          rdAck = 1'b1;
          @(posedge clk);
          #1 rdAck = 1'b0;
          @(negedge clk);
          checkOutput("clrSuppressed", 32'(flagClr), 32'd0);
          repeat (2) @(posedge clk);
          #1 rdAck = 1'b1;
          @(posedge clk);
          #1 rdAck = 1'b0;
          @(negedge clk);
          checkOutput("clrPulse", 32'(flagClr), 32'd1);
          @(negedge clk);
          checkOutput("clrOneCycle", 32'(flagClr), 32'd0);
        end
      end
    join

    // Reset in the middle of data bit 4 of an all-ones frame
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b1);
    rxIn = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checkOutput("midFrameBusy", 32'(busy), 32'd1);
    #3 reset = 1'b1;
    #1;
    lastExpData = '0;
    checkOutput("abortDataOut", 32'(dataOut), 32'd0);
    checkOutput("abortFlagDin", 32'(flagDin), 32'd0);
    checkOutput("abortFlagSet", 32'(flagSet), 32'd0);
    checkOutput("abortFlagClr", 32'(flagClr), 32'd0);
    checkOutput("abortBusy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    checkOutput("abortNoStrobe", strobes, framesSent);
    checkOutput("postResetData", 32'(dataOut), 32'(lastExpData));
    applyStimulus(8'h55, 1'b1, 20);

    // Back-to-back frames with no idle gap
    applyStimulus(8'h01, 1'b1, 0);
    applyStimulus(8'h80, 1'b1, 20);

    // Randomized frames, mostly good, some framing errors
    for (int n = 0; n < 12; n++) begin
      applyStimulus(DB'($urandom_range(0, 255)), 1'($urandom_range(0, 3) != 0),
                    int'($urandom_range(12, 40)));
    end

    repeat (20) @(posedge clk);
    #1;
    checkOutput("queueEmpty", expQ.size(), 32'd0);
    checkOutput("strobeCount", strobes, framesSent);
    checkOutput("finalData", 32'(dataOut), 32'(lastExpData));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
